// File: rtl/pio_cmd_fifo.sv
// Avalon-MM programmed-I/O command FIFO: the CPU pushes command words through a
// register window and a valid/ready port streams them downstream.
`timescale 1ns/1ps

module pio_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_outEn;
  logic             r_irqEmptyEn;
  logic             r_irqOvfEn;
  logic [WIDTH-1:0] r_lastPop;

  logic             w_wrStrobe;
  logic             w_pushReq;
  logic             w_statusWr;
  logic             w_controlWr;
  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_valid;
  logic             w_pop;
  logic             w_accept;
  logic             w_drop;
  logic [WIDTH-1:0] w_head;
  logic [31:0]      w_readdata;

  assign w_wrStrobe  = chipselect & ~write_n;
  assign w_pushReq   = w_wrStrobe & (address == ADDR_DATA);
  assign w_statusWr  = w_wrStrobe & (address == ADDR_STATUS);
  assign w_controlWr = w_wrStrobe & (address == ADDR_CONTROL);
  assign w_flush     = w_controlWr & writedata[3];

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));
  assign w_head  = r_mem[r_rptr];

  // Flush beats a pop on the same edge; a pop frees the slot a full-FIFO push needs.
  assign w_valid  = r_outEn & ~w_empty;
  assign w_pop    = w_valid & out_ready & ~w_flush;
  assign w_accept = w_pushReq & (~w_full | w_pop);
  assign w_drop   = w_pushReq & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wptr] <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_lastPop <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr    <= r_rptr + AW'(1);
        r_lastPop <= w_head;
      end
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow   <= 1'b0;
      r_outEn      <= 1'b0;
      r_irqEmptyEn <= 1'b0;
      r_irqOvfEn   <= 1'b0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (w_statusWr && writedata[2]) begin
        r_overflow <= 1'b0;
      end
      if (w_controlWr) begin
        r_outEn      <= writedata[0];
        r_irqEmptyEn <= writedata[1];
        r_irqOvfEn   <= writedata[2];
      end
    end
  end

  always_comb begin
    w_readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) begin
          w_readdata = 32'(w_head);
        end
      end
      ADDR_STATUS: begin
        w_readdata[0]     = w_empty;
        w_readdata[1]     = w_full;
        w_readdata[2]     = r_overflow;
        w_readdata[24:16] = 9'(r_level);
      end
      ADDR_CONTROL: begin
        w_readdata[0] = r_outEn;
        w_readdata[1] = r_irqEmptyEn;
        w_readdata[2] = r_irqOvfEn;
      end
      default: w_readdata = '0;
    endcase
  end

  // Storage is never reset, so the empty case must fall back to the last popped word.
  assign out_port  = w_empty ? r_lastPop : w_head;
  assign out_valid = w_valid;
  assign readdata  = w_readdata;
  assign irq       = (r_irqEmptyEn & w_empty) | (r_irqOvfEn & r_overflow);

endmodule

// File: tb/tb_pio_cmd_fifo.sv
// Self-checking bench for pio_cmd_fifo (WIDTH=8, DEPTH=4): directed scenarios
// plus randomized traffic, both compared each cycle against a queue-based model.
`timescale 1ns/1ps

module tb_pio_cmd_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             out_valid;
  logic             out_ready;
  logic             irq;

  int checkCount;
  int errorCount;

  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] modelLast;
  logic             modelOvf;
  logic             modelOutEn;
  logic             modelEmptyEn;
  logic             modelOvfEn;

  pio_cmd_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelLast    = '0;
    modelOvf     = 1'b0;
    modelOutEn   = 1'b0;
    modelEmptyEn = 1'b0;
    modelOvfEn   = 1'b0;
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: if (modelQ.size() > 0) v = 32'(modelQ[0]);
      2'd1: v = (32'(modelQ.size()) << 16) |
                {29'b0, modelOvf, modelQ.size() == DEPTH, modelQ.size() == 0};
      2'd2: v = {29'b0, modelOvfEn, modelEmptyEn, modelOutEn};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Applies one clock edge worth of register-map rules to the queue model.
  task automatic modelStep();
    bit wr;
    bit flushW;
    bit pop;
    int sizeBefore;
    wr         = chipselect && !write_n;
    flushW     = wr && address == 2'd2 && writedata[3];
    pop        = modelOutEn && modelQ.size() > 0 && out_ready && !flushW;
    sizeBefore = modelQ.size();
    if (flushW) modelQ.delete();
    if (pop) begin
      modelLast = modelQ[0];
      void'(modelQ.pop_front());
    end
    if (wr && address == 2'd0) begin
      if (sizeBefore < DEPTH || pop) modelQ.push_back(writedata[WIDTH-1:0]);
      else modelOvf = 1'b1;
    end
    if (wr && address == 2'd1 && writedata[2]) modelOvf = 1'b0;
    if (wr && address == 2'd2) begin
      modelOutEn   = writedata[0];
      modelEmptyEn = writedata[1];
      modelOvfEn   = writedata[2];
    end
  endtask

  task automatic compareModel();
    logic expValid;
    logic [WIDTH-1:0] expPort;
    expValid = modelOutEn && modelQ.size() > 0;
    expPort  = (modelQ.size() > 0) ? modelQ[0] : modelLast;
    checkOutput("outValid", 32'(out_valid), 32'(expValid));
    checkOutput("outPort", 32'(out_port), 32'(expPort));
    checkOutput("irq", 32'(irq),
                32'((modelEmptyEn && modelQ.size() == 0) || (modelOvfEn && modelOvf)));
    checkOutput("readdata", readdata, modelRead(address));
  endtask

  // Drive inputs at the falling edge, compare, then let the rising edge commit.
  task automatic driveInputs(input logic cs, input logic wn, input logic [1:0] addr,
                             input logic [31:0] data, input logic ready);
    @(negedge clk);
    chipselect = cs;
    write_n    = wn;
    address    = addr;
    writedata  = data;
    out_ready  = ready;
    #1;
  endtask

  task automatic finishCycle();
    compareModel();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic cs, input logic wn, input logic [1:0] addr,
                               input logic [31:0] data, input logic ready);
    driveInputs(cs, wn, addr, data, ready);
    finishCycle();
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data, input logic ready);
    applyStimulus(1'b1, 1'b0, addr, data, ready);
  endtask

  task automatic readReg(input string tag, input logic [1:0] addr, input logic [31:0] expected,
                         input logic ready);
    driveInputs(1'b0, 1'b1, addr, 32'h0, ready);
    checkOutput(tag, readdata, expected);
    finishCycle();
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    modelReset();
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
    writedata  = '0;
    out_ready  = 1'b0;

    #7;
    checkOutput("resetValid", 32'(out_valid), 32'h0);
    checkOutput("resetPort", 32'(out_port), 32'h0);
    checkOutput("resetIrq", 32'(irq), 32'h0);
    checkOutput("resetStatus", readdata, 32'h1);
    address = 2'd2;
    #1;
    checkOutput("resetControl", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic streaming with out_ready held high.
    writeReg(2'd2, 32'h1, 1'b1);
    writeReg(2'd0, 32'h11, 1'b1);
    checkOutput("stream0", 32'(out_port), 32'h11);
    writeReg(2'd0, 32'hFFFF_FF22, 1'b1);
    checkOutput("stream1", 32'(out_port), 32'h22);
    writeReg(2'd0, 32'h33, 1'b1);
    checkOutput("stream2", 32'(out_port), 32'h33);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
    checkOutput("streamEmptyValid", 32'(out_valid), 32'h0);
    checkOutput("streamHoldPort", 32'(out_port), 32'h33);

    // Overflow while stalled.
    writeReg(2'd2, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) writeReg(2'd0, 32'hA0 + i, 1'b0);
    readReg("ovfStatus", 2'd1, 32'h0004_0006, 1'b0);
    writeReg(2'd2, 32'h1, 1'b1);
    for (int i = 0; i < 4; i++) readReg("ovfDrain", 2'd0, 32'hA0 + i, 1'b1);
    readReg("ovfAfterDrain", 2'd1, 32'h0000_0005, 1'b0);
    writeReg(2'd1, 32'h4, 1'b0);

    // Push into a full FIFO with a simultaneous pop.
    writeReg(2'd2, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) writeReg(2'd0, 32'hB0 + i, 1'b0);
    writeReg(2'd2, 32'h1, 1'b0);
    writeReg(2'd0, 32'h55, 1'b1);
    readReg("fullPushStatus", 2'd1, 32'h0004_0002, 1'b0);
    readReg("fullPush0", 2'd0, 32'hB1, 1'b1);
    readReg("fullPush1", 2'd0, 32'hB2, 1'b1);
    readReg("fullPush2", 2'd0, 32'hB3, 1'b1);
    readReg("fullPush3", 2'd0, 32'h55, 1'b1);

    // Interrupt sources.
    writeReg(2'd2, 32'h6, 1'b0);
    checkOutput("irqEmpty", 32'(irq), 32'h1);
    writeReg(2'd0, 32'h77, 1'b0);
    checkOutput("irqNotEmpty", 32'(irq), 32'h0);
    for (int i = 0; i < 4; i++) writeReg(2'd0, 32'h78 + i, 1'b0);
    checkOutput("irqOverflow", 32'(irq), 32'h1);
    writeReg(2'd1, 32'h4, 1'b0);
    checkOutput("irqOvfCleared", 32'(irq), 32'h0);
    readReg("ovfClearedStatus", 2'd1, 32'h0004_0002, 1'b0);

    // Flush with a pending pop.
    writeReg(2'd2, 32'h8, 1'b0);
    for (int i = 0; i < 3; i++) writeReg(2'd0, 32'hC0 + i, 1'b0);
    writeReg(2'd2, 32'h1, 1'b0);
    writeReg(2'd2, 32'h9, 1'b1);
    checkOutput("flushValid", 32'(out_valid), 32'h0);
    checkOutput("flushPort", 32'(out_port), 32'h55);
    readReg("flushStatus", 2'd1, 32'h0000_0001, 1'b1);
    readReg("flushControl", 2'd2, 32'h0000_0001, 1'b1);

    // Asynchronous reset between edges.
    writeReg(2'd0, 32'hD0, 1'b0);
    writeReg(2'd0, 32'hD1, 1'b0);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd1;
    out_ready  = 1'b0;
    #2;
    checkOutput("preResetValid", 32'(out_valid), 32'h1);
    reset_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncValid", 32'(out_valid), 32'h0);
    checkOutput("asyncPort", 32'(out_port), 32'h0);
    checkOutput("asyncIrq", 32'(irq), 32'h0);
    checkOutput("asyncStatus", readdata, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    readReg("postResetStatus", 2'd1, 32'h1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [31:0] data;
      int          sel;
      cs   = ($urandom_range(0, 9) < 7);
      wn   = ($urandom_range(0, 4) == 0);
      sel  = $urandom_range(0, 15);
      addr = (sel < 9) ? 2'd0 : (sel < 11) ? 2'd1 : (sel < 14) ? 2'd2 : 2'd3;
      data = $urandom;
      if (addr == 2'd2) begin
        data[3] = ($urandom_range(0, 7) == 0);
        data[0] = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(cs, wn, addr, data, ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
